// File: rtl/mips_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
// Holds the op codes, the data word width and the FSM state names.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_iter_core.sv
// One combinational iteration of the multiply/divide datapath.
// Multiply: shift-add, right shift. Divide: restoring trial-subtract, left shift.
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             i_isDiv,
  input  logic [WIDTH-1:0] i_accHi,
  input  logic [WIDTH-1:0] i_accLo,
  input  logic [WIDTH-1:0] i_opB,
  output logic [WIDTH-1:0] o_accHi,
  output logic [WIDTH-1:0] o_accLo
);

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;
  logic             w_fits;

  assign w_addend  = i_accLo[0] ? i_opB : '0;
  assign w_sum     = {1'b0, i_accHi} + {1'b0, w_addend};
  // The remainder is always below the divisor, so the low WIDTH bits of the difference suffice.
  assign w_shifted = {i_accHi, i_accLo[WIDTH-1]};
  assign w_diff    = w_shifted[WIDTH-1:0] - i_opB;
  assign w_fits    = w_shifted >= {1'b0, i_opB};

  always_comb begin
    o_accHi = w_sum[WIDTH:1];
    o_accLo = {w_sum[0], i_accLo[WIDTH-1:1]};
    if (i_isDiv) begin
      o_accHi = w_fits ? w_diff : w_shifted[WIDTH-1:0];
      o_accLo = {i_accLo[WIDTH-2:0], w_fits};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: 1 cycle latch, WIDTH iterations,
// 1 cycle sign fix and write-back; done pulses the cycle after write-back.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e        r_state;
  md_state_e        w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_accHi;
  logic [WIDTH-1:0] r_accLo;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_rawA;
  logic             r_signA;
  logic             r_signB;
  logic             r_isDiv;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_dbz;

  logic             w_start;
  logic             w_opIsDiv;
  logic             w_opSigned;
  logic             w_negA;
  logic             w_negB;
  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic [WIDTH-1:0] w_stepHi;
  logic [WIDTH-1:0] w_stepLo;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prodFix;
  logic [WIDTH-1:0] w_quoFix;
  logic [WIDTH-1:0] w_remFix;

  assign w_start    = (r_state == MD_IDLE) && start;
  assign w_opIsDiv  = (op == MD_DIV) || (op == MD_DIVU);
  assign w_opSigned = (op == MD_MULT) || (op == MD_DIV);
  assign w_negA     = w_opSigned && srcA[WIDTH-1];
  assign w_negB     = w_opSigned && srcB[WIDTH-1];
  assign w_absA     = w_negA ? -srcA : srcA;
  assign w_absB     = w_negB ? -srcB : srcB;

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .i_isDiv (r_isDiv),
    .i_accHi (r_accHi),
    .i_accLo (r_accLo),
    .i_opB   (r_opB),
    .o_accHi (w_stepHi),
    .o_accLo (w_stepLo)
  );

  assign w_prod    = {r_accHi, r_accLo};
  assign w_prodFix = (r_signA ^ r_signB) ? -w_prod : w_prod;
  assign w_quoFix  = (r_signA ^ r_signB) ? -r_accLo : r_accLo;
  assign w_remFix  = r_signA ? -r_accHi : r_accHi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= MD_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      MD_IDLE: if (start) w_nextState = MD_CALC;
      MD_CALC: if (r_cnt == CNT_W'(WIDTH - 1)) w_nextState = MD_FIX;
      MD_FIX:  w_nextState = MD_IDLE;
      default: w_nextState = MD_IDLE;
    endcase
  end

  // Datapath and architectural HI/LO; a zero divisor overrides the iterated result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_accHi <= '0;
      r_accLo <= '0;
      r_opB   <= '0;
      r_rawA  <= '0;
      r_signA <= 1'b0;
      r_signB <= 1'b0;
      r_isDiv <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        MD_IDLE: begin
          if (w_start) begin
            r_cnt   <= '0;
            r_accHi <= '0;
            r_accLo <= w_absA;
            r_opB   <= w_absB;
            r_rawA  <= srcA;
            r_signA <= w_negA;
            r_signB <= w_negB;
            r_isDiv <= w_opIsDiv;
            r_dbz   <= 1'b0;
          end else begin
            if (mthi) r_hi <= srcA;
            if (mtlo) r_lo <= srcA;
          end
        end
        MD_CALC: begin
          r_accHi <= w_stepHi;
          r_accLo <= w_stepLo;
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        MD_FIX: begin
          r_done <= 1'b1;
          if (r_isDiv && (r_opB == '0)) begin
            r_hi  <= r_rawA;
            r_lo  <= '1;
            r_dbz <= 1'b1;
          end else if (r_isDiv) begin
            r_hi <= w_remFix;
            r_lo <= w_quoFix;
          end else begin
            r_hi <= w_prodFix[2*WIDTH-1:WIDTH];
            r_lo <= w_prodFix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != MD_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
